// File: rtl/assert_pkg.sv
// Shared types and widths for the assertion reporter.
package assert_pkg;

  localparam int CODE_W     = 8;
  localparam int SRC_MAX_W  = 4;
  localparam int ERR_CNT_W  = 32;
  localparam int DROP_CNT_W = 16;

  // One queued report. src is sized for the largest source count and
  // truncated at the top-level output.
  typedef struct packed {
    logic                 is_err;
    logic [SRC_MAX_W-1:0] src;
    logic [CODE_W-1:0]    code;
  } rpt_entry_t;

  localparam int ENTRY_W = $bits(rpt_entry_t);

endpackage

// File: rtl/assert_fifo.sv
// Report FIFO: synchronous write, combinational head read.
module assert_fifo
  import assert_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               pop,
  output logic               valid,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic               empty;
  logic               do_push;
  logic               do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign valid   = !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/assert_reporter.sv
// Collects per-source error/warning pulses, arbitrates them round-robin
// into a report FIFO and keeps saturating event statistics.
module assert_reporter
  import assert_pkg::*;
#(
  parameter int NSRC         = 4,
  parameter int DEPTH        = 8,
  parameter int HOLDOFF      = 16,
  parameter bit STOP_ON_WARN = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NSRC-1:0]         src_err,
  input  logic [NSRC-1:0]         src_warn,
  input  logic [8*NSRC-1:0]       src_code,
  output logic                    rpt_valid,
  input  logic                    rpt_ready,
  output logic                    rpt_is_err,
  output logic [$clog2(NSRC)-1:0] rpt_src,
  output logic [CODE_W-1:0]       rpt_code,
  output logic [ERR_CNT_W-1:0]    errors,
  output logic [ERR_CNT_W-1:0]    warnings,
  output logic [DROP_CNT_W-1:0]   drops,
  output logic                    message_on,
  output logic                    stop_req
);

  localparam int SW = $clog2(NSRC);
  localparam int HW = $clog2(HOLDOFF + 2);

  logic [HW-1:0]     holdoff_cnt;
  logic [NSRC-1:0]   pend_err, pend_warn;
  logic [CODE_W-1:0] code_err  [NSRC];
  logic [CODE_W-1:0] code_warn [NSRC];
  logic [SW-1:0]     rr_ptr;

  logic              gnt_valid, gnt_is_err;
  logic [SW-1:0]     gnt_src;
  logic [CODE_W-1:0] gnt_code;
  logic [NSRC-1:0]   ev_err, ev_warn, clr_err, clr_warn, drop_err, drop_warn;
  logic [5:0]        drop_n;
  logic [DROP_CNT_W:0] drops_sum;
  logic              fifo_full;
  rpt_entry_t        push_ent, head_ent;
  logic              unused_src_bits;

  assign ev_err  = src_err  & {NSRC{message_on}};
  assign ev_warn = src_warn & {NSRC{message_on}};

  // Round-robin search from rr_ptr; errors win over warnings within a source.
  always_comb begin
    gnt_valid  = 1'b0;
    gnt_is_err = 1'b0;
    gnt_src    = '0;
    for (int i = 0; i < NSRC; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NSRC;
      if (!gnt_valid && (pend_err[idx] || pend_warn[idx])) begin
        gnt_valid  = 1'b1;
        gnt_src    = SW'(idx);
        gnt_is_err = pend_err[idx];
      end
    end
    if (fifo_full) gnt_valid = 1'b0;
    gnt_code = gnt_is_err ? code_err[gnt_src] : code_warn[gnt_src];
  end

  // Per-source clear and drop decode, plus the number of drops this cycle.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NSRC; i++) begin
      clr_err[i]   = gnt_valid && gnt_is_err  && (int'(gnt_src) == i);
      clr_warn[i]  = gnt_valid && !gnt_is_err && (int'(gnt_src) == i);
      drop_err[i]  = ev_err[i]  && pend_err[i]  && !clr_err[i];
      drop_warn[i] = ev_warn[i] && pend_warn[i] && !clr_warn[i];
      drop_n = drop_n + 6'(drop_err[i]) + 6'(drop_warn[i]);
    end
    drops_sum = {1'b0, drops} + (DROP_CNT_W+1)'(drop_n);
  end

  // Pending flags: a new event wins over a same-cycle grant clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_err  <= '0;
      pend_warn <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (ev_err[i])       pend_err[i]  <= 1'b1;
        else if (clr_err[i]) pend_err[i]  <= 1'b0;
        if (ev_warn[i])       pend_warn[i] <= 1'b1;
        else if (clr_warn[i]) pend_warn[i] <= 1'b0;
      end
    end
  end

  // Code capture only into a free (or just-freed) slot; a dropped event never overwrites.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (ev_err[i] && (!pend_err[i] || clr_err[i]))
        code_err[i] <= src_code[i*CODE_W +: CODE_W];
      if (ev_warn[i] && (!pend_warn[i] || clr_warn[i]))
        code_warn[i] <= src_code[i*CODE_W +: CODE_W];
    end
  end

  // Holdoff timer, arbitration pointer, statistics and sticky stop request.
  always_ff @(posedge clk) begin
    if (reset) begin
      holdoff_cnt <= HW'(HOLDOFF);
      message_on  <= 1'b0;
      rr_ptr      <= '0;
      errors      <= '0;
      warnings    <= '0;
      drops       <= '0;
      stop_req    <= 1'b0;
    end else begin
      if (!message_on) begin
        if (holdoff_cnt <= HW'(1)) message_on <= 1'b1;
        if (holdoff_cnt != '0)     holdoff_cnt <= holdoff_cnt - HW'(1);
      end
      if (gnt_valid) begin
        rr_ptr <= (int'(gnt_src) == NSRC - 1) ? '0 : gnt_src + SW'(1);
        if (gnt_is_err) begin
          if (errors != '1) errors <= errors + 1'b1;
        end else begin
          if (warnings != '1) warnings <= warnings + 1'b1;
        end
      end
      drops <= drops_sum[DROP_CNT_W] ? '1 : drops_sum[DROP_CNT_W-1:0];
      if ((errors != '0) || (STOP_ON_WARN && (warnings != '0))) stop_req <= 1'b1;
    end
  end

  assign push_ent.is_err = gnt_is_err;
  assign push_ent.src    = SRC_MAX_W'(gnt_src);
  assign push_ent.code   = gnt_code;

  assert_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (gnt_valid),
    .wdata (push_ent),
    .pop   (rpt_ready),
    .valid (rpt_valid),
    .rdata (head_ent),
    .full  (fifo_full)
  );

  assign rpt_is_err      = head_ent.is_err;
  assign rpt_src         = head_ent.src[SW-1:0];
  assign rpt_code        = head_ent.code;
  assign unused_src_bits = ^head_ent.src;

endmodule

// File: tb/tb_assert_reporter.sv
// Directed bench for assert_reporter with default parameters.
module tb_assert_reporter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src_err, src_warn;
  logic [31:0] src_code;
  logic        rpt_valid, rpt_ready, rpt_is_err;
  logic [1:0]  rpt_src;
  logic [7:0]  rpt_code;
  logic [31:0] errors, warnings;
  logic [15:0] drops;
  logic        message_on, stop_req;

  int total = 0;
  int bad   = 0;
  int exp_err  = 0;
  int exp_warn = 0;

  typedef struct {
    logic       is_err;
    int         src;
    logic [7:0] code;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  assert_reporter #(.NSRC(4), .DEPTH(8), .HOLDOFF(16), .STOP_ON_WARN(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_err    (src_err),
    .src_warn   (src_warn),
    .src_code   (src_code),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_is_err (rpt_is_err),
    .rpt_src    (rpt_src),
    .rpt_code   (rpt_code),
    .errors     (errors),
    .warnings   (warnings),
    .drops      (drops),
    .message_on (message_on),
    .stop_req   (stop_req)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    src_err  = '0;
    src_warn = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"},   32'(rpt_valid),  32'd0);
    chk({tag, "_errors"},  errors,          32'd0);
    chk({tag, "_warns"},   warnings,        32'd0);
    chk({tag, "_drops"},   32'(drops),      32'd0);
    chk({tag, "_msg_on"},  32'(message_on), 32'd0);
    chk({tag, "_stop"},    32'(stop_req),   32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2, 8'h3C};
    vecs[1] = '{1'b0, 1, 8'hC3};
    vecs[2] = '{1'b1, 0, 8'h00};
    vecs[3] = '{1'b0, 2, 8'hFF};
    vecs[4] = '{1'b1, 1, 8'h7E};
    vecs[5] = '{1'b0, 3, 8'h81};
    vecs[6] = '{1'b1, 3, 8'h5A};   // ends on source 3 so the arbiter restarts at 0

    rpt_ready = 1'b0;
    src_code  = '0;
    do_reset();
    chk_cleared("reset");

    // Holdoff: event in cycle 5 ignored, event in cycle 20 reported.
    step_n(5);
    src_err = 4'b0001; src_code[7:0] = 8'h5C;
    step();
    src_err = '0;
    step_n(9);                                   // cycle 15
    chk("holdoff_msg_low", 32'(message_on), 32'd0);
    chk("holdoff_no_entry", 32'(rpt_valid), 32'd0);
    step();                                      // cycle 16
    chk("holdoff_msg_high", 32'(message_on), 32'd1);
    step_n(4);                                   // cycle 20
    src_err = 4'b0001; src_code[7:0] = 8'hA5;
    step();
    src_err = '0;
    chk("enq_latency_valid", 32'(rpt_valid), 32'd0);
    chk("enq_latency_errs", errors, 32'd0);
    step();                                      // cycle 22
    exp_err = 1;
    chk("holdoff_valid", 32'(rpt_valid), 32'd1);
    chk("holdoff_code", 32'(rpt_code), 32'hA5);
    chk("holdoff_src", 32'(rpt_src), 32'd0);
    chk("holdoff_is_err", 32'(rpt_is_err), 32'd1);
    chk("holdoff_errors", errors, 32'(exp_err));
    chk("stop_not_yet", 32'(stop_req), 32'd0);
    step();
    chk("stop_next_cycle", 32'(stop_req), 32'd1);
    rpt_ready = 1'b1;
    step();
    chk("pop_empty", 32'(rpt_valid), 32'd0);

    // Single-event vectors.
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].is_err) begin
        src_err[vecs[v].src] = 1'b1;
        exp_err++;
      end else begin
        src_warn[vecs[v].src] = 1'b1;
        exp_warn++;
      end
      src_code[vecs[v].src*8 +: 8] = vecs[v].code;
      step();
      src_err = '0; src_warn = '0;
      chk("vec_pending_only", 32'(rpt_valid), 32'd0);
      step();
      chk("vec_valid", 32'(rpt_valid), 32'd1);
      chk("vec_is_err", 32'(rpt_is_err), 32'(vecs[v].is_err));
      chk("vec_src", 32'(rpt_src), 32'(vecs[v].src));
      chk("vec_code", 32'(rpt_code), 32'(vecs[v].code));
      chk("vec_errors", errors, 32'(exp_err));
      chk("vec_warnings", warnings, 32'(exp_warn));
      chk("vec_stop_sticky", 32'(stop_req), 32'd1);
      step();
      chk("vec_popped", 32'(rpt_valid), 32'd0);
    end

    // Fairness: all four sources in one cycle, reported 0,1,2,3.
    src_err  = 4'hF;
    src_code = 32'h43424140;
    step();
    src_err = '0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("rr_valid", 32'(rpt_valid), 32'd1);
      chk("rr_src", 32'(rpt_src), 32'(k));
      chk("rr_code", 32'(rpt_code), 32'h40 + 32'(k));
      step();
    end
    exp_err += 4;
    chk("rr_drained", 32'(rpt_valid), 32'd0);
    chk("rr_errors", errors, 32'(exp_err));

    // Rotation: after granting source 1, sources 3 then 0 are served.
    src_err = 4'b0010; src_code[15:8] = 8'h51;
    step(); src_err = '0; step();
    chk("rot_first_src", 32'(rpt_src), 32'd1);
    step();
    src_err = 4'b1001; src_code[7:0] = 8'h60; src_code[31:24] = 8'h63;
    step(); src_err = '0; step();
    chk("rot_src_a", 32'(rpt_src), 32'd3);
    chk("rot_code_a", 32'(rpt_code), 32'h63);
    step();
    chk("rot_src_b", 32'(rpt_src), 32'd0);
    chk("rot_code_b", 32'(rpt_code), 32'h60);
    step();
    exp_err += 3;
    chk("rot_drained", 32'(rpt_valid), 32'd0);

    // Priority: error and warning on source 2 together.
    src_err = 4'b0100; src_warn = 4'b0100; src_code[23:16] = 8'h11;
    step(); src_err = '0; src_warn = '0; step();
    chk("prio_first_err", 32'(rpt_is_err), 32'd1);
    chk("prio_first_src", 32'(rpt_src), 32'd2);
    chk("prio_first_code", 32'(rpt_code), 32'h11);
    step();
    chk("prio_second_warn", 32'(rpt_is_err), 32'd0);
    chk("prio_second_valid", 32'(rpt_valid), 32'd1);
    chk("prio_second_code", 32'(rpt_code), 32'h11);
    exp_err++; exp_warn++;
    chk("prio_errors", errors, 32'(exp_err));
    chk("prio_warnings", warnings, 32'(exp_warn));
    step();

    // Backpressure: ten errors on source 1, FIFO of eight, consumer stalled.
    rpt_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      src_err = 4'b0010; src_code[15:8] = 8'(i);
      step();
      src_err = '0;
      step();
    end
    chk("bp_drops", 32'(drops), 32'd1);
    chk("bp_errors", errors, 32'(exp_err + 8));
    chk("bp_valid", 32'(rpt_valid), 32'd1);
    rpt_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("bp_drain_valid", 32'(rpt_valid), 32'd1);
      chk("bp_drain_code", 32'(rpt_code), 32'(k));
      step();
    end
    exp_err += 9;
    chk("bp_drained", 32'(rpt_valid), 32'd0);
    chk("bp_errors_final", errors, 32'(exp_err));
    chk("bp_drops_final", 32'(drops), 32'd1);

    // Warning only: no stop request with STOP_ON_WARN=0.
    do_reset();
    chk_cleared("reset2");
    step_n(16);
    chk("reset2_msg_on", 32'(message_on), 32'd1);
    src_warn = 4'b1000; src_code[31:24] = 8'h77;
    step(); src_warn = '0; step();
    chk("warn_only_is_err", 32'(rpt_is_err), 32'd0);
    chk("warn_only_src", 32'(rpt_src), 32'd3);
    step_n(3);
    chk("warn_only_count", warnings, 32'd1);
    chk("warn_only_no_stop", 32'(stop_req), 32'd0);

    // Reset mid-run with five entries queued and one event in flight.
    rpt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      src_err = 4'b0001; src_code[7:0] = 8'h80 + 8'(i);
      step();
      src_err = '0;
      step();
    end
    chk("midrun_errors", errors, 32'd5);
    chk("midrun_stop", 32'(stop_req), 32'd1);
    chk("midrun_valid", 32'(rpt_valid), 32'd1);
    src_err = 4'b0010;
    reset   = 1'b1;
    step();
    src_err = '0;
    chk_cleared("midrun_reset");
    reset = 1'b0;
    step_n(20);
    chk("midrun_no_stale", 32'(rpt_valid), 32'd0);
    chk("midrun_no_stale_errs", errors, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
